rob_gpr: RTL
============

Name: rob_gpr

Overview:
- Reorder buffer for integer results, holding 2^ROB_WIDTH entries of type rob_entry (valid, arch_num, data).
- Dispatch allocates entries in program order and receives the ROB tag used for renaming.
- CDB broadcasts (cdb_t) fill entries out of order.
- Completed entries retire in order to the GPR register file; two read ports serve operand fetch at dispatch.

Parameters:
- ROB_WIDTH, 4, tag width; depth = 2^ROB_WIDTH entries (package value).
- REG_WIDTH, 5, architectural register number width (package value).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- alloc_req  input  1  dispatch requests one entry
- alloc_arch_num  input  REG_WIDTH  destination register of the allocating instruction
- alloc_ack  output  1  allocation accepted this cycle
- alloc_tag  output  ROB_WIDTH  tag of the entry allocated (current tail)
- full  output  1  no free entry
- cdb  input  cdb_t  result broadcast (valid, tag, data)
- commit_valid  output  1  head entry complete and retirable
- commit_ready  input  1  register file accepts the commit
- commit_tag  output  ROB_WIDTH  head tag
- commit_arch_num  output  REG_WIDTH  head destination
- commit_data  output  32  head result
- flush  input  1  misprediction; discard all entries
- rd_tag[0:1]  input  ROB_WIDTH  operand lookup tags
- rd_valid[0:1]  output  1  looked-up entry has its result
- rd_data[0:1]  output  32  looked-up result

Behaviour:
- State: head, tail (ROB_WIDTH bits, wrap modulo depth), count (ROB_WIDTH+1 bits), and entries[depth] of rob_entry.
- Reset (clk edge with reset=1): head=tail=count=0, all entry.valid=0. Resulting outputs: full=0, commit_valid=0, alloc_ack=0, rd_valid=0, alloc_tag=0. Data fields are don't-care.
- Combinational outputs:
  - full = (count == 2^ROB_WIDTH).
  - alloc_ack = alloc_req && !full && !flush.
  - alloc_tag = tail, presented whether or not alloc_req is high.
- Allocate, on alloc_ack:
  - entries[tail].valid <= 0 and entries[tail].arch_num <= alloc_arch_num.
  - tail <= tail+1, wrapping 15 to 0.
- CDB write: when tag_match(cdb, t) holds and entry t lies in the occupied window [head, head+count), set entries[t].data <= cdb.data and valid <= 1. A broadcast to an unoccupied tag is ignored.
- Commit:
  - commit_valid = (count != 0) && entries[head].valid.
  - commit_tag, commit_arch_num and commit_data are driven combinationally from entries[head].
  - Fire = commit_valid && commit_ready && !flush. On fire, head <= head+1 and entries[head].valid <= 0.
- count update: next count = count + alloc_ack - fire. Simultaneous allocate and commit leaves count unchanged.
- Boundary cases:
  - When full, allocation is refused even if a commit fires in the same cycle; full is evaluated from registered count, with no same-cycle reuse.
  - Allocating into an empty ROB: the new entry is not committable in the same cycle.
  - A CDB write to the head entry makes commit_valid rise on the next cycle only; there is no CDB-to-commit bypass.
  - A CDB write and an allocate to the same tag cannot be legal in one cycle; the allocate wins.
- Flush has the highest priority. At the clock edge: head=tail=count=0 and all valid=0. Any same-cycle alloc, CDB write or commit is suppressed.
- Read ports: rd_valid[i] = entries[rd_tag[i]].valid; rd_data[i] = entries[rd_tag[i]].data. Combinational, with no occupancy check; the requester only looks up live tags.
- Reset asserted mid-operation behaves identically to power-up reset and takes priority over flush.

Optional Feature:
- Macro: ROB_CDB_BYPASS_EN.
- Defined: when tag_match(cdb, rd_tag[i]) holds in the current cycle, rd_valid[i]=1 and rd_data[i]=cdb.data. Dispatch thereby sees results broadcast in the same cycle.
- Undefined: read ports reflect registered entry state only; a result becomes visible the cycle after its broadcast.

Test Plan:
- Reset, then allocate 3 entries with arch 1,2,3 → alloc_tag 0,1,2; count=3; commit_valid=0.
- CDB tag 1 data 0xAAAA, then tag 0 data 0x5555, commit_ready=1 → commits in order: arch 1 / 0x5555, then arch 2 / 0xAAAA; tag 2 is held.
- Allocate 16 with no commits → full=1; 17th alloc_req gives alloc_ack=0. Fill and commit tag 0 while alloc_req is high → no alloc that cycle; next cycle alloc_tag=0 (wrap).
- 5 entries live, then flush together with alloc_req, CDB and commit_ready → next cycle count=0, commit_valid=0, alloc_tag=0; no commit fired.
- CDB tag 4 (unallocated, head=0, count=2) data 0x1234 → rd_tag=4 gives rd_valid=0.
- With ROB_CDB_BYPASS_EN: CDB tag 2 data 0xBEEF and rd_tag[0]=2 in the same cycle → rd_valid[0]=1, rd_data=0xBEEF in that cycle. Without the macro: rd_valid[0]=0 that cycle and 1 the next.

Source files
------------

// File: rtl/rob_gpr.sv
// rob_gpr: reorder buffer for integer results.
// Dispatch allocates entries in program order, CDB broadcasts complete them
// out of order, and the head entry retires in order to the GPR file.
// Two combinational read ports serve operand lookup at dispatch.
// Optional macro ROB_CDB_BYPASS_EN: read ports also see the current-cycle CDB.

package rob_gpr_pkg;
  localparam int unsigned ROB_WIDTH  = 4;
  localparam int unsigned REG_WIDTH  = 5;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ROB_DEPTH  = 1 << ROB_WIDTH;

  typedef logic [ROB_WIDTH-1:0] rob_tag_t;
  typedef logic [ROB_WIDTH:0]   rob_cnt_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_WIDTH-1:0]  arch_num;
    logic [DATA_WIDTH-1:0] data;
  } rob_entry;

  typedef struct packed {
    logic                  valid;
    rob_tag_t              tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  function automatic logic tag_match(cdb_t c, rob_tag_t t);
    return c.valid && (c.tag == t);
  endfunction
endpackage

module rob_gpr
  import rob_gpr_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  input  logic [REG_WIDTH-1:0]  alloc_arch_num,
  output logic                  alloc_ack,
  output logic [ROB_WIDTH-1:0]  alloc_tag,
  output logic                  full,
  input  cdb_t                  cdb,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output logic [ROB_WIDTH-1:0]  commit_tag,
  output logic [REG_WIDTH-1:0]  commit_arch_num,
  output logic [DATA_WIDTH-1:0] commit_data,
  input  logic                  flush,
  input  logic [ROB_WIDTH-1:0]  rd_tag   [0:1],
  output logic                  rd_valid [0:1],
  output logic [DATA_WIDTH-1:0] rd_data  [0:1]
);

  rob_tag_t head_q, head_d;
  rob_tag_t tail_q, tail_d;
  rob_cnt_t count_q, count_d;
  rob_entry entries_q [ROB_DEPTH];
  rob_entry entries_d [ROB_DEPTH];

  logic in_win [ROB_DEPTH];
  logic fire;

  // Status, allocation handshake and commit view of the head entry.
  always_comb begin
    full            = (count_q == rob_cnt_t'(ROB_DEPTH));
    alloc_ack       = alloc_req && !full && !flush;
    alloc_tag       = tail_q;
    commit_valid    = (count_q != '0) && entries_q[head_q].valid;
    commit_tag      = head_q;
    commit_arch_num = entries_q[head_q].arch_num;
    commit_data     = entries_q[head_q].data;
    fire            = commit_valid && commit_ready && !flush;
  end

  // Occupancy: an entry is live when its distance from head is below count.
  always_comb begin
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      in_win[i] = {1'b0, rob_tag_t'(rob_tag_t'(i) - head_q)} < count_q;
    end
  end

  // Next-state: flush clears everything, otherwise CDB fill, commit, allocate.
  // Allocate is applied last so it overrides a same-tag CDB write.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        if (tag_match(cdb, rob_tag_t'(i)) && in_win[i]) begin
          entries_d[i].valid = 1'b1;
          entries_d[i].data  = cdb.data;
        end
      end
      if (fire) begin
        entries_d[head_q].valid = 1'b0;
        head_d = head_q + rob_tag_t'(1);
      end
      if (alloc_ack) begin
        entries_d[tail_q].valid    = 1'b0;
        entries_d[tail_q].arch_num = alloc_arch_num;
        tail_d = tail_q + rob_tag_t'(1);
      end
      count_d = count_q + rob_cnt_t'(alloc_ack) - rob_cnt_t'(fire);
    end
  end

  // State registers; reset clears pointers and valid bits, data is left as is.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // Operand lookup ports; no occupancy check, requester only asks live tags.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_valid[p] = entries_q[rd_tag[p]].valid;
      rd_data[p]  = entries_q[rd_tag[p]].data;
`ifdef ROB_CDB_BYPASS_EN
      if (tag_match(cdb, rd_tag[p])) begin
        rd_valid[p] = 1'b1;
        rd_data[p]  = cdb.data;
      end
`endif
    end
  end

endmodule
